// File: rtl/reg_wb_ctrl.sv
// ---------------------------------------------------------------------------
// reg_wb_ctrl
//   Register-file writeback controller. Merges single-cycle ALU results with
//   long-latency LSU results (buffered in a small FIFO) onto the single
//   register-file write port. It also keeps a pending-write scoreboard so
//   that decode stalls on RAW/WAW hazards against outstanding LSU results.
//
// Parameters
//   DEPTH       LSU result FIFO entries (power of two, >= 2)
//   STARVE_MAX  cycles a non-empty FIFO head may lose to the ALU before a
//               forced drain
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   alu_valid_W/alu_rd_W/
//   alu_data_W                  ALU result offered this cycle
//   lsu_valid/lsu_rd/lsu_data   LSU result offered (valid/ready)
//   lsu_ready                   FIFO not full
//   issue_valid_D/issue_rd_D/
//   issue_long_D/rs1_D/rs2_D    decode-stage issue information
//   stall_D                     decode must hold (combinational)
//   alu_hold                    ALU pipe must not present a result next cycle
//   rd_W/Wdata/we_reg_W         registered register-file write port
// ---------------------------------------------------------------------------
module reg_wb_ctrl #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid_W,
  input  logic [4:0]  alu_rd_W,
  input  logic [31:0] alu_data_W,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  input  logic        issue_valid_D,
  input  logic [4:0]  issue_rd_D,
  input  logic        issue_long_D,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  output logic        stall_D,
  output logic        alu_hold,
  output logic [4:0]  rd_W,
  output logic [31:0] Wdata,
  output logic        we_reg_W
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  // NORMAL: ALU has priority. HOLD: upstream told to skip next cycle.
  // FORCE: FIFO head wins the port regardless of alu_valid_W.
  typedef enum logic [1:0] {
    ARB_NORMAL,
    ARB_HOLD,
    ARB_FORCE
  } arb_state_e;

  arb_state_e state_q, state_d;

  // FIFO storage (data only, never reset) and control
  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          alu_win;

  logic [SW-1:0] starve_q, starve_d;

  // Write port registers
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          src_lsu_q, src_lsu_d;

  // Scoreboard
  logic [31:0]   pending_q, pending_d;
  logic [31:0]   set_vec;
  logic [31:0]   clr_vec;

  assign fifo_empty = (count_q == '0);
  assign lsu_ready  = (count_q != CW'(DEPTH));
  assign push       = lsu_valid && lsu_ready;

  assign rd_W       = rd_q;
  assign Wdata      = wdata_q;
  assign we_reg_W   = we_q;
  assign alu_hold   = (state_q == ARB_HOLD);

  // Hazard check: x0 is never pending, so it is masked explicitly.
  assign stall_D = issue_valid_D &&
                   (((rs1_D      != 5'd0) && pending_q[rs1_D])  ||
                    ((rs2_D      != 5'd0) && pending_q[rs2_D])  ||
                    ((issue_rd_D != 5'd0) && pending_q[issue_rd_D]));

  // Port arbitration and write-port next state
  always_comb begin
    pop       = 1'b0;
    alu_win   = 1'b0;
    rd_d      = rd_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    src_lsu_d = 1'b0;

    if ((state_q == ARB_FORCE) && !fifo_empty) begin
      pop = 1'b1;
    end else if (alu_valid_W) begin
      alu_win = 1'b1;
    end else if (!fifo_empty) begin
      pop = 1'b1;
    end

    if (alu_win) begin
      rd_d    = alu_rd_W;
      wdata_d = alu_data_W;
      we_d    = (alu_rd_W != 5'd0);
    end else if (pop) begin
      rd_d      = mem_rd[rd_ptr_q];
      wdata_d   = mem_data[rd_ptr_q];
      we_d      = (mem_rd[rd_ptr_q] != 5'd0);
      src_lsu_d = 1'b1;
    end
  end

  // FIFO pointers/occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Starvation counter saturates so an ALU win during HOLD cannot overflow it.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (alu_win && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Arbitration FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_NORMAL: if (starve_d == SW'(STARVE_MAX)) state_d = ARB_HOLD;
      ARB_HOLD:   state_d = ARB_FORCE;
      ARB_FORCE:  state_d = ARB_NORMAL;
      default:    state_d = ARB_NORMAL;
    endcase
  end

  // Scoreboard: clear when an LSU-sourced write is presented, set on a
  // non-stalled long issue. Set is applied last so the newer op wins.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (we_q && src_lsu_q) clr_vec = 32'd1 << rd_q;
    if (issue_valid_D && issue_long_D && (issue_rd_D != 5'd0) && !stall_D)
      set_vec = 32'd1 << issue_rd_D;
    pending_d = ((pending_q & ~clr_vec) | set_vec) & ~32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      pending_q <= '0;
      rd_q      <= 5'd0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      src_lsu_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      rd_q      <= rd_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      src_lsu_q <= src_lsu_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr_q]   <= lsu_rd;
      mem_data[wr_ptr_q] <= lsu_data;
    end
  end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
module tb_reg_wb_ctrl;

  logic        clk;
  logic        rst;
  logic        alu_valid_W;
  logic [4:0]  alu_rd_W;
  logic [31:0] alu_data_W;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        issue_valid_D;
  logic [4:0]  issue_rd_D;
  logic        issue_long_D;
  logic [4:0]  rs1_D;
  logic [4:0]  rs2_D;
  logic        stall_D;
  logic        alu_hold;
  logic [4:0]  rd_W;
  logic [31:0] Wdata;
  logic        we_reg_W;

  int n_vec = 0;
  int n_err = 0;
  logic hold_prev = 1'b0;

  reg_wb_ctrl #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid_W   (alu_valid_W),
    .alu_rd_W      (alu_rd_W),
    .alu_data_W    (alu_data_W),
    .lsu_valid     (lsu_valid),
    .lsu_rd        (lsu_rd),
    .lsu_data      (lsu_data),
    .lsu_ready     (lsu_ready),
    .issue_valid_D (issue_valid_D),
    .issue_rd_D    (issue_rd_D),
    .issue_long_D  (issue_long_D),
    .rs1_D         (rs1_D),
    .rs2_D         (rs2_D),
    .stall_D       (stall_D),
    .alu_hold      (alu_hold),
    .rd_W          (rd_W),
    .Wdata         (Wdata),
    .we_reg_W      (we_reg_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // The ALU must not present a result in the cycle after alu_hold.
  always @(posedge clk) begin
    if (!rst && hold_prev) begin
      n_vec++;
      assert (alu_valid_W === 1'b0) else begin
        n_err++;
        $error("FAIL proto_alu_after_hold: got %0b want 0", alu_valid_W);
      end
    end
    hold_prev <= alu_hold;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid_W = 0; alu_rd_W = 0; alu_data_W = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid_D = 0; issue_rd_D = 0; issue_long_D = 0; rs1_D = 0; rs2_D = 0;

    // Reset state
    tick(); tick();
    chk("rst_rd_W", rd_W, 0);
    chk("rst_Wdata", Wdata, 0);
    chk("rst_we", we_reg_W, 0);
    chk("rst_hold", alu_hold, 0);
    chk("rst_ready", lsu_ready, 1);
    chk("rst_stall", stall_D, 0);
    rst = 1'b0;
    tick();

    // ALU write, one-cycle latency
    alu_valid_W = 1; alu_rd_W = 5; alu_data_W = 32'h11;
    tick();
    alu_valid_W = 0;
    chk("alu_rd", rd_W, 5);
    chk("alu_data", Wdata, 32'h11);
    chk("alu_we", we_reg_W, 1);
    tick();
    chk("alu_we_drop", we_reg_W, 0);
    chk("idle_rd_hold", rd_W, 5);
    chk("idle_data_hold", Wdata, 32'h11);

    // LSU push, appears two cycles later
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hDEADBEEF;
    tick();
    lsu_valid = 0;
    chk("lsu_t1_we", we_reg_W, 0);
    tick();
    chk("lsu_t2_rd", rd_W, 7);
    chk("lsu_t2_data", Wdata, 32'hDEADBEEF);
    chk("lsu_t2_we", we_reg_W, 1);
    tick();
    chk("lsu_t3_we", we_reg_W, 0);

    // ALU write to x0: no write enable
    alu_valid_W = 1; alu_rd_W = 0; alu_data_W = 32'h55;
    tick();
    alu_valid_W = 0;
    chk("x0_we", we_reg_W, 0);

    // Scoreboard RAW / WAW on x3
    issue_valid_D = 1; issue_long_D = 1; issue_rd_D = 3;
    #1 chk("issue3_stall", stall_D, 0);
    tick();
    issue_long_D = 0; issue_rd_D = 0; rs1_D = 3;
    #1 chk("raw3_stall", stall_D, 1);
    rs1_D = 0; rs2_D = 3;
    #1 chk("raw3_rs2_stall", stall_D, 1);
    rs2_D = 0; issue_long_D = 1; issue_rd_D = 3;
    #1 chk("waw3_stall", stall_D, 1);
    issue_valid_D = 0;
    #1 chk("novalid_stall", stall_D, 0);
    issue_long_D = 0; issue_rd_D = 0;
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h333;
    tick();
    lsu_valid = 0;
    issue_valid_D = 1; rs1_D = 3;
    #1 chk("x3_push_stall", stall_D, 1);
    tick();
    chk("x3_port_we", we_reg_W, 1);
    chk("x3_port_rd", rd_W, 3);
    chk("x3_port_stall", stall_D, 1);
    tick();
    chk("x3_cleared_stall", stall_D, 0);
    issue_valid_D = 0; rs1_D = 0;

    // Starvation: ALU busy, four pushes fill the FIFO
    for (int c = 0; c < 10; c++) begin
      alu_valid_W = 1; alu_rd_W = 1; alu_data_W = c;
      lsu_valid = (c < 4); lsu_rd = 5'(10 + c); lsu_data = 32'hA0 + c;
      #1;
      chk($sformatf("starve_ready_c%0d", c), lsu_ready, (c < 4) ? 1 : 0);
      chk($sformatf("starve_hold_c%0d", c), alu_hold, (c == 9) ? 1 : 0);
      if (c == 5) chk("starve_alu_wins", rd_W, 1);
      tick();
    end
    alu_valid_W = 0; lsu_valid = 0;
    #1;
    chk("force_hold_gone", alu_hold, 0);
    chk("force_ready", lsu_ready, 0);
    chk("force_port_alu", Wdata, 9);
    tick();
    chk("drain_ready", lsu_ready, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_rd", k), rd_W, 10 + k);
      chk($sformatf("drain%0d_data", k), Wdata, 32'hA0 + k);
      chk($sformatf("drain%0d_we", k), we_reg_W, 1);
      tick();
    end
    chk("drain_done_we", we_reg_W, 0);

    // Same-edge clear and set of x9: set wins
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    tick();
    lsu_valid = 0;
    tick();
    chk("x9_port_rd", rd_W, 9);
    issue_valid_D = 1; issue_long_D = 1; issue_rd_D = 9;
    #1 chk("x9_issue_stall", stall_D, 0);
    tick();
    issue_long_D = 0; issue_rd_D = 0; rs1_D = 9;
    #1 chk("x9_pending_stall", stall_D, 1);

    // Reset mid-operation with FIFO entries and pending bits
    rs1_D = 0; issue_long_D = 1; issue_rd_D = 4;
    tick();
    issue_valid_D = 0; issue_long_D = 0; issue_rd_D = 0;
    for (int c = 0; c < 3; c++) begin
      alu_valid_W = 1; alu_rd_W = 2; alu_data_W = 32'h200 + c;
      lsu_valid = 1; lsu_rd = 5'(20 + c); lsu_data = 32'hC0 + c;
      tick();
    end
    lsu_valid = 0;
    chk("pre_rst_we", we_reg_W, 1);
    issue_valid_D = 1; rs1_D = 4; rs2_D = 9;
    #1 chk("pre_rst_stall", stall_D, 1);
    alu_valid_W = 0;
    rst = 1'b1;
    #1;
    chk("midrst_ready", lsu_ready, 1);
    chk("midrst_we", we_reg_W, 0);
    chk("midrst_rd", rd_W, 0);
    chk("midrst_stall", stall_D, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_rst_we%0d", k), we_reg_W, 0);
    end
    chk("post_rst_stall", stall_D, 0);
    issue_valid_D = 0; rs1_D = 0; rs2_D = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
